// File: rtl/vend_sequencer_if.sv
// Bundle of the vending controller's coin/selection/config inputs, the
// dispenser handshakes and the status outputs. The controller uses the
// slave view and its environment uses the master view.
interface vend_sequencer_if;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       sel_valid;
  logic [1:0] sel_id;
  logic       cancel;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_price;
  logic       vend_ack;
  logic       change_ack;
  logic       vend_req;
  logic [1:0] vend_id;
  logic       change_req;
  logic       coin_reject;
  logic       sel_err;
  logic       vend_fail;
  logic [7:0] credit;
  logic       busy;

  modport slave (
    input  coin_valid, coin_type, sel_valid, sel_id, cancel,
    input  cfg_we, cfg_addr, cfg_price, vend_ack, change_ack,
    output vend_req, vend_id, change_req, coin_reject, sel_err,
    output vend_fail, credit, busy
  );

  modport master (
    output coin_valid, coin_type, sel_valid, sel_id, cancel,
    output cfg_we, cfg_addr, cfg_price, vend_ack, change_ack,
    input  vend_req, vend_id, change_req, coin_reject, sel_err,
    input  vend_fail, credit, busy
  );
endinterface

// File: rtl/vend_sequencer.sv
// Multi-product vending controller: accumulates coin credit, arbitrates
// cancel/selection/coin events, runs the item dispenser handshake with a
// timeout refund, and pays change back one nickel at a time.
module vend_sequencer #(
  parameter int unsigned PRICE_DEFAULT = 15,
  parameter int unsigned MAX_CREDIT    = 95,
  parameter int unsigned VEND_TIMEOUT  = 16,
  parameter bit          AUTO_CHANGE   = 1'b1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  vend_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_CHANGE = 2'd2
  } state_e;

  localparam int unsigned    TW       = $clog2(VEND_TIMEOUT + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(VEND_TIMEOUT - 1);
  localparam logic [8:0]     MAX9     = 9'(MAX_CREDIT);
  localparam logic [7:0]     PDEF     = 8'(PRICE_DEFAULT);
  localparam logic [7:0]     NICKEL   = 8'd5;

  // Prices are stored in cents and must be whole nickels.
  function automatic logic is_mult5(input logic [7:0] v);
    return (v % 8'd5) == 8'd0;
  endfunction

  // Coin value in cents; a slug is worth nothing and is always rejected.
  function automatic logic [7:0] coin_value(input logic [1:0] t);
    logic [7:0] v;
    case (t)
      2'b00:   v = 8'd5;
      2'b01:   v = 8'd10;
      2'b10:   v = 8'd25;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

  state_e        state_q, state_d;
  logic [7:0]    credit_q, credit_d;
  logic [1:0]    vend_id_q, vend_id_d;
  logic [7:0]    price_q [4];
  logic [TW-1:0] tmo_q, tmo_d;
  logic          coin_reject_q, coin_reject_d;
  logic          sel_err_q, sel_err_d;
  logic          vend_fail_q, vend_fail_d;
  logic          vend_req_q, change_req_q, busy_q;

  logic [7:0]    coin_val_s;
  logic          coin_ok_s;
  logic [7:0]    sel_price_s;
  logic [7:0]    refund_s;

  assign coin_val_s  = coin_value(bus.coin_type);
  // The sum is widened so the ceiling compare cannot wrap.
  assign coin_ok_s   = (bus.coin_type != 2'b11) &&
                       (({1'b0, credit_q} + {1'b0, coin_val_s}) <= MAX9);
  // Selection and refund both use the price held before any same-cycle write.
  assign sel_price_s = price_q[bus.sel_id];
  assign refund_s    = credit_q + price_q[vend_id_q];

  // Next-state, credit and pulse decisions for the current state.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    vend_id_d     = vend_id_q;
    tmo_d         = tmo_q;
    coin_reject_d = 1'b0;
    sel_err_d     = 1'b0;
    vend_fail_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cancel) begin
          coin_reject_d = bus.coin_valid;
          if (credit_q != 8'd0) begin
            state_d = ST_CHANGE;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (bus.sel_valid) begin
          if ((sel_price_s == 8'd0) || (credit_q < sel_price_s)) begin
            // Refused selection still lets a same-cycle coin through.
            sel_err_d = 1'b1;
            if (bus.coin_valid && coin_ok_s) begin
              credit_d = credit_q + coin_val_s;
            end else begin
              coin_reject_d = bus.coin_valid;
            end
          end else begin
            credit_d      = credit_q - sel_price_s;
            vend_id_d     = bus.sel_id;
            tmo_d         = '0;
            state_d       = ST_VEND;
            coin_reject_d = bus.coin_valid;
          end
        end else if (bus.coin_valid) begin
          if (coin_ok_s) begin
            credit_d = credit_q + coin_val_s;
          end else begin
            coin_reject_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_VEND: begin
        coin_reject_d = bus.coin_valid;
        if (bus.vend_ack) begin
          // An ack on the final timeout cycle still counts as a good vend.
          if (AUTO_CHANGE && (credit_q >= NICKEL)) begin
            state_d = ST_CHANGE;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (tmo_q == TMO_LAST) begin
          vend_fail_d = 1'b1;
          credit_d    = refund_s;
          // A refund of nothing (item price rewritten to 0) has no change to pay.
          if (refund_s != 8'd0) begin
            state_d = ST_CHANGE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_CHANGE: begin
        coin_reject_d = bus.coin_valid;
        if (bus.change_ack) begin
          if (credit_q <= NICKEL) begin
            credit_d = 8'd0;
            state_d  = ST_IDLE;
          end else begin
            credit_d = credit_q - NICKEL;
          end
        end else begin
          state_d = ST_CHANGE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = 8'd0;
      end
    endcase
  end

  // State, credit, pulse and request registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      credit_q      <= 8'd0;
      vend_id_q     <= 2'd0;
      tmo_q         <= '0;
      coin_reject_q <= 1'b0;
      sel_err_q     <= 1'b0;
      vend_fail_q   <= 1'b0;
      vend_req_q    <= 1'b0;
      change_req_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      vend_id_q     <= vend_id_d;
      tmo_q         <= tmo_d;
      coin_reject_q <= coin_reject_d;
      sel_err_q     <= sel_err_d;
      vend_fail_q   <= vend_fail_d;
      vend_req_q    <= (state_d == ST_VEND);
      change_req_q  <= (state_d == ST_CHANGE);
      busy_q        <= (state_d != ST_IDLE);
    end
  end

  // Price table; writes land in any state but only for whole-nickel prices.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < 4; i++) begin
        price_q[i] <= PDEF;
      end
    end else if (bus.cfg_we && is_mult5(bus.cfg_price)) begin
      price_q[bus.cfg_addr] <= bus.cfg_price;
    end else begin
      price_q <= price_q;
    end
  end

  assign bus.vend_req    = vend_req_q;
  assign bus.vend_id     = vend_id_q;
  assign bus.change_req  = change_req_q;
  assign bus.coin_reject = coin_reject_q;
  assign bus.sel_err     = sel_err_q;
  assign bus.vend_fail   = vend_fail_q;
  assign bus.credit      = credit_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Bench for vend_sequencer: directed scenarios with literal expectations,
// then randomized traffic, all compared each cycle against a cents-level model.
module tb_vend_sequencer;
  localparam int PD = 15;
  localparam int MC = 95;
  localparam int VT = 16;
  localparam bit AC = 1'b1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vend_sequencer_if bus();

  vend_sequencer #(
    .PRICE_DEFAULT(PD), .MAX_CREDIT(MC), .VEND_TIMEOUT(VT), .AUTO_CHANGE(AC)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus    (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model: mode 0 = idle, 1 = dispensing, 2 = paying change.
  int m_mode, m_credit, m_vid, m_vcyc, m_rej, m_serr, m_fail;
  int m_price [4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int cents(input int t);
    case (t)
      0:       return 5;
      1:       return 10;
      2:       return 25;
      default: return 0;
    endcase
  endfunction

  task automatic take_coin();
    int v;
    v = cents(int'(bus.coin_type));
    if (v > 0 && m_credit + v <= MC) m_credit += v;
    else m_rej = 1;
  endtask

  // Advance the model by one clock using the inputs sampled at this edge.
  task automatic model_step();
    int np [4];
    int p;
    np = m_price;
    if (bus.cfg_we && (int'(bus.cfg_price) % 5 == 0)) np[bus.cfg_addr] = int'(bus.cfg_price);
    if (reset) begin
      m_mode = 0; m_credit = 0; m_vid = 0; m_vcyc = 0;
      m_rej = 0; m_serr = 0; m_fail = 0;
      for (int i = 0; i < 4; i++) m_price[i] = PD;
      return;
    end
    m_rej = 0; m_serr = 0; m_fail = 0;
    if (m_mode == 0) begin
      if (bus.cancel) begin
        if (bus.coin_valid) m_rej = 1;
        if (m_credit > 0) m_mode = 2;
      end else if (bus.sel_valid) begin
        p = m_price[bus.sel_id];
        if (p == 0 || m_credit < p) begin
          m_serr = 1;
          if (bus.coin_valid) take_coin();
        end else begin
          m_credit -= p; m_vid = int'(bus.sel_id); m_mode = 1; m_vcyc = 0;
          if (bus.coin_valid) m_rej = 1;
        end
      end else if (bus.coin_valid) begin
        take_coin();
      end
    end else if (m_mode == 1) begin
      if (bus.coin_valid) m_rej = 1;
      m_vcyc++;
      if (bus.vend_ack) begin
        m_mode = (AC && m_credit >= 5) ? 2 : 0;
      end else if (m_vcyc == VT) begin
        m_fail = 1;
        m_credit += m_price[m_vid];
        m_mode = (m_credit > 0) ? 2 : 0;
      end
    end else begin
      if (bus.coin_valid) m_rej = 1;
      if (bus.change_ack) begin
        m_credit -= 5;
        if (m_credit <= 0) begin m_credit = 0; m_mode = 0; end
      end
    end
    m_price = np;
  endtask

  // Compare every DUT output with the model mid-cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("credit",      int'(bus.credit),      m_credit);
      check("vend_req",    int'(bus.vend_req),    int'(m_mode == 1));
      check("vend_id",     int'(bus.vend_id),     m_vid);
      check("change_req",  int'(bus.change_req),  int'(m_mode == 2));
      check("busy",        int'(bus.busy),        int'(m_mode != 0));
      check("coin_reject", int'(bus.coin_reject), m_rej);
      check("sel_err",     int'(bus.sel_err),     m_serr);
      check("vend_fail",   int'(bus.vend_fail),   m_fail);
    end
  end

  task automatic clear_inputs();
    reset = 1'b0;
    bus.coin_valid = 1'b0; bus.coin_type = 2'd0;
    bus.sel_valid = 1'b0;  bus.sel_id = 2'd0;
    bus.cancel = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_addr = 2'd0; bus.cfg_price = 8'd0;
    bus.vend_ack = 1'b0; bus.change_ack = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    clear_inputs();
  endtask

  task automatic coin(input int t);
    bus.coin_valid = 1'b1; bus.coin_type = 2'(t);
  endtask

  task automatic sel(input int id);
    bus.sel_valid = 1'b1; bus.sel_id = 2'(id);
  endtask

  task automatic cfg(input int a, input int p);
    bus.cfg_we = 1'b1; bus.cfg_addr = 2'(a); bus.cfg_price = 8'(p);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && m_mode != 0; i++) begin
      bus.vend_ack = (m_mode == 1); bus.change_ack = (m_mode == 2);
      tick();
    end
    check("drain_idle", int'(bus.busy), 0);
  endtask

  initial begin
    clear_inputs();
    for (int i = 0; i < 4; i++) m_price[i] = PD;
    reset = 1'b1; tick();
    reset = 1'b1; tick();
    cmp_en = 1'b1;
    check("rst_credit", int'(bus.credit), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_vend_id", int'(bus.vend_id), 0);

    // Dime + nickel, buy item 0, ack on the second request cycle.
    coin(1); tick(); check("t1_credit10", int'(bus.credit), 10);
    coin(0); tick(); check("t1_credit15", int'(bus.credit), 15);
    sel(0);  tick(); check("t1_credit0", int'(bus.credit), 0);
    check("t1_vreq_a", int'(bus.vend_req), 1);
    check("t1_vid", int'(bus.vend_id), 0);
    tick(); check("t1_vreq_b", int'(bus.vend_req), 1);
    bus.vend_ack = 1'b1; tick();
    check("t1_vreq_off", int'(bus.vend_req), 0);
    check("t1_no_change", int'(bus.change_req), 0);
    check("t1_idle", int'(bus.busy), 0);

    // Quarter, buy item 1, two nickels of change.
    coin(2); tick(); check("t2_credit25", int'(bus.credit), 25);
    sel(1);  tick(); check("t2_credit10", int'(bus.credit), 10);
    bus.vend_ack = 1'b1; tick(); check("t2_creq", int'(bus.change_req), 1);
    bus.change_ack = 1'b1; tick(); check("t2_credit5", int'(bus.credit), 5);
    check("t2_creq_hold", int'(bus.change_req), 1);
    bus.change_ack = 1'b1; tick(); check("t2_credit0", int'(bus.credit), 0);
    check("t2_creq_off", int'(bus.change_req), 0);
    check("t2_idle", int'(bus.busy), 0);

    // Credit ceiling, slug, coin during a vend.
    coin(2); tick(); coin(2); tick(); coin(2); tick(); coin(1); tick(); coin(1); tick();
    check("t3_credit95", int'(bus.credit), 95);
    coin(0); tick(); check("t3_rej_ceiling", int'(bus.coin_reject), 1);
    check("t3_credit_held", int'(bus.credit), 95);
    coin(3); tick(); check("t3_rej_slug", int'(bus.coin_reject), 1);
    bus.cancel = 1'b1; tick(); drain();
    coin(1); tick(); coin(1); tick(); sel(0); tick();
    coin(1); tick(); check("t3_rej_vend", int'(bus.coin_reject), 1);
    check("t3_credit5", int'(bus.credit), 5);
    drain();

    // Disabled item, rejected odd price, same-cycle write uses old price.
    coin(1); tick(); coin(1); tick();
    cfg(2, 0); tick(); cfg(3, 12); tick();
    sel(2); tick(); check("t4_sel_err", int'(bus.sel_err), 1);
    check("t4_credit20", int'(bus.credit), 20);
    sel(3); cfg(3, 5); tick(); check("t4_old_price", int'(bus.credit), 5);
    check("t4_vid3", int'(bus.vend_id), 3);
    drain();

    // Dispenser timeout refunds 15 cents as three nickels.
    coin(1); tick(); coin(0); tick(); sel(0); tick();
    for (int i = 0; i < VT - 1; i++) begin
      tick(); check("t5_no_fail_yet", int'(bus.vend_fail), 0);
    end
    tick(); check("t5_fail", int'(bus.vend_fail), 1);
    check("t5_refund", int'(bus.credit), 15);
    check("t5_creq", int'(bus.change_req), 1);
    for (int i = 0; i < 3; i++) begin bus.change_ack = 1'b1; tick(); end
    check("t5_paid", int'(bus.credit), 0);
    check("t5_idle", int'(bus.busy), 0);
    // Ack on the last permitted cycle wins over the timeout.
    coin(1); tick(); coin(0); tick(); sel(0); tick();
    for (int i = 0; i < VT - 1; i++) tick();
    bus.vend_ack = 1'b1; tick();
    check("t5_late_ack_nofail", int'(bus.vend_fail), 0);
    check("t5_late_ack_idle", int'(bus.busy), 0);

    // Cancel with a same-cycle dime, then reset mid-change.
    coin(1); tick();
    bus.cancel = 1'b1; coin(1); tick();
    check("t6_rej", int'(bus.coin_reject), 1);
    check("t6_creq", int'(bus.change_req), 1);
    check("t6_credit10", int'(bus.credit), 10);
    bus.change_ack = 1'b1; tick(); check("t6_credit5", int'(bus.credit), 5);
    reset = 1'b1; tick();
    check("t6_rst_creq", int'(bus.change_req), 0);
    check("t6_rst_credit", int'(bus.credit), 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      reset          = ($urandom_range(0, 199) == 0);
      bus.coin_valid = ($urandom_range(0, 2) == 0);
      bus.coin_type  = 2'($urandom_range(0, 3));
      bus.sel_valid  = ($urandom_range(0, 5) == 0);
      bus.sel_id     = 2'($urandom_range(0, 3));
      bus.cancel     = ($urandom_range(0, 19) == 0);
      bus.cfg_we     = ($urandom_range(0, 15) == 0);
      bus.cfg_addr   = 2'($urandom_range(0, 3));
      bus.cfg_price  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 60))
                                                   : 8'(5 * $urandom_range(0, 8));
      bus.vend_ack   = (m_mode == 1) ? ($urandom_range(0, 7) == 0)
                                     : ($urandom_range(0, 9) == 0);
      bus.change_ack = ($urandom_range(0, 2) != 0);
      tick();
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
